seven_seg_capture: RTL and testbench

SEVEN_SEG_CAPTURE -- requirements
Module: seven_seg_capture

---
 rtl/seven_seg_pkg.sv | 46 ++++
 rtl/seven_seg_decode.sv | 28 ++
 rtl/seven_seg_capture.sv | 219 +++++++++++++++++++++
 tb/tb_seven_seg_capture.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants, state type and helpers for the seven-segment capture block and its decoder.
package seven_seg_pkg;

    localparam int DEFAULT_SETTLE_CYCLES  = 16;
    localparam int DEFAULT_TIMEOUT_CYCLES = 2_000_000;

    localparam logic [3:0] ANODE_DIGIT0 = 4'b0111;
    localparam logic [3:0] ANODE_DIGIT1 = 4'b1011;
    localparam logic [3:0] ANODE_DIGIT2 = 4'b1101;
    localparam logic [3:0] ANODE_DIGIT3 = 4'b1110;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } capture_state_e;

    // Slots that must already be filled before digit slot idx may be accepted.
    function automatic logic [3:0] lowMask(input logic [1:0] idx);
        logic [3:0] mask;
        case (idx)
            2'd0:    mask = 4'b0000;
            2'd1:    mask = 4'b0001;
            2'd2:    mask = 4'b0011;
            default: mask = 4'b0111;
        endcase
        return mask;
    endfunction

    function automatic logic [15:0] bcdToBinary(input logic [15:0] bcd);
        return 16'(bcd[15:12]) * 16'd1000 + 16'(bcd[11:8]) * 16'd100
             + 16'(bcd[7:4]) * 16'd10 + 16'(bcd[3:0]);
    endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational inverse of the active-low segment table: cathode pattern to BCD digit.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] bcd_o,
    output logic       valid_o
);

    always_comb begin
        bcd_o   = 4'd0;
        valid_o = 1'b1;
        case (pattern_i)
            SEG_0:   bcd_o = 4'd0;
            SEG_1:   bcd_o = 4'd1;
            SEG_2:   bcd_o = 4'd2;
            SEG_3:   bcd_o = 4'd3;
            SEG_4:   bcd_o = 4'd4;
            SEG_5:   bcd_o = 4'd5;
            SEG_6:   bcd_o = 4'd6;
            SEG_7:   bcd_o = 4'd7;
            SEG_8:   bcd_o = 4'd8;
            SEG_9:   bcd_o = 4'd9;
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Snoops a multiplexed 4-digit seven-segment bus and reconstructs the displayed number
// once every digit has been seen in scan order 0..3.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int SETTLE_CYCLES  = DEFAULT_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clock_100Mhz,
    input  logic        reset,
    input  logic [3:0]  Anode_Activate_in,
    input  logic [6:0]  LED_out_in,
    output logic [15:0] captured_number,
    output logic [15:0] digit_bcd,
    output logic        frame_valid,
    output logic        decode_error,
    output logic        stale
);

    localparam int SETTLE_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SETTLE_W-1:0]  SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_MAX = TIMEOUT_W'(TIMEOUT_CYCLES);

    logic [3:0] anodeMeta_q, anodeSync_q, anodePrev_q;
    logic [6:0] cathodeMeta_q, cathodeSync_q, cathodePrev_q;
    logic       anodeChanged, cathodeChanged;

    logic [1:0] anodeIdx;
    logic       anodeValid;
    logic [3:0] segBcd;
    logic       segValid;

    capture_state_e        state_q, state_d;
    logic [SETTLE_W-1:0]   settleCnt_q, settleCnt_d;
    logic                  sample;

    logic [3:0]  seenMask_q, seenMask_d;
    logic [15:0] staged_q, staged_d;
    logic        pending_q, pending_d;
    logic [15:0] capturedNum_q, capturedNum_d;
    logic [15:0] digitBcd_q, digitBcd_d;
    logic        frameValid_q, frameValid_d;
    logic        decodeErr_q, decodeErr_d;

    logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
    logic                 stale_q, stale_d;

    // The *Prev copies exist only to detect changes on the synchronised buses.
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            anodeMeta_q   <= '0;
            anodeSync_q   <= '0;
            anodePrev_q   <= '0;
            cathodeMeta_q <= '0;
            cathodeSync_q <= '0;
            cathodePrev_q <= '0;
        end else begin
            anodeMeta_q   <= Anode_Activate_in;
            anodeSync_q   <= anodeMeta_q;
            anodePrev_q   <= anodeSync_q;
            cathodeMeta_q <= LED_out_in;
            cathodeSync_q <= cathodeMeta_q;
            cathodePrev_q <= cathodeSync_q;
        end
    end

    assign anodeChanged   = (anodeSync_q != anodePrev_q);
    assign cathodeChanged = (cathodeSync_q != cathodePrev_q);

    always_comb begin
        anodeIdx   = 2'd0;
        anodeValid = 1'b1;
        case (anodeSync_q)
            ANODE_DIGIT0: anodeIdx = 2'd0;
            ANODE_DIGIT1: anodeIdx = 2'd1;
            ANODE_DIGIT2: anodeIdx = 2'd2;
            ANODE_DIGIT3: anodeIdx = 2'd3;
            default:      anodeValid = 1'b0;
        endcase
    end

    seven_seg_decode u_decode (
        .pattern_i (cathodeSync_q),
        .bcd_o     (segBcd),
        .valid_o   (segValid)
    );

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            settleCnt_q <= '0;
        end else begin
            state_q     <= state_d;
            settleCnt_q <= settleCnt_d;
        end
    end

    // HOLD ignores cathode activity so a held digit is sampled exactly once.
    always_comb begin
        state_d     = state_q;
        settleCnt_d = settleCnt_q;
        sample      = 1'b0;
        if (!anodeValid) begin
            state_d     = IDLE;
            settleCnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d     = SETTLE;
                    settleCnt_d = '0;
                end
                SETTLE: begin
                    if (anodeChanged || cathodeChanged) begin
                        settleCnt_d = '0;
                    end else if (settleCnt_q == SETTLE_LAST) begin
                        state_d     = HOLD;
                        settleCnt_d = '0;
                        sample      = 1'b1;
                    end else begin
                        settleCnt_d = settleCnt_q + SETTLE_W'(1);
                    end
                end
                HOLD: begin
                    if (anodeChanged) begin
                        state_d     = SETTLE;
                        settleCnt_d = '0;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    settleCnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            seenMask_q    <= '0;
            staged_q      <= '0;
            pending_q     <= 1'b0;
            capturedNum_q <= '0;
            digitBcd_q    <= '0;
            frameValid_q  <= 1'b0;
            decodeErr_q   <= 1'b0;
        end else begin
            seenMask_q    <= seenMask_d;
            staged_q      <= staged_d;
            pending_q     <= pending_d;
            capturedNum_q <= capturedNum_d;
            digitBcd_q    <= digitBcd_d;
            frameValid_q  <= frameValid_d;
            decodeErr_q   <= decodeErr_d;
        end
    end

    // Slot 0 always restarts a frame; later slots must arrive strictly in order.
    always_comb begin
        seenMask_d    = seenMask_q;
        staged_d      = staged_q;
        pending_d     = 1'b0;
        capturedNum_d = capturedNum_q;
        digitBcd_d    = digitBcd_q;
        frameValid_d  = 1'b0;
        decodeErr_d   = 1'b0;

        if (pending_q) begin
            frameValid_d  = 1'b1;
            digitBcd_d    = staged_q;
            capturedNum_d = bcdToBinary(staged_q);
            seenMask_d    = '0;
        end

        if (sample) begin
            if (!segValid) begin
                decodeErr_d = 1'b1;
                seenMask_d  = '0;
            end else if (anodeIdx == 2'd0) begin
                seenMask_d       = 4'b0001;
                staged_d[15:12]  = segBcd;
            end else if (((seenMask_q & lowMask(anodeIdx)) == lowMask(anodeIdx))
                         && !seenMask_q[anodeIdx]) begin
                seenMask_d[anodeIdx]              = 1'b1;
                staged_d[{~anodeIdx, 2'b00} +: 4] = segBcd;
                pending_d                         = (anodeIdx == 2'd3);
            end else begin
                seenMask_d = '0;
            end
        end
    end

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            timeout_q <= '0;
            stale_q   <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
            stale_q   <= stale_d;
        end
    end

    always_comb begin
        timeout_d = timeout_q;
        if (anodeChanged) begin
            timeout_d = '0;
        end else if (timeout_q != TIMEOUT_MAX) begin
            timeout_d = timeout_q + TIMEOUT_W'(1);
        end
        stale_d = (timeout_d == TIMEOUT_MAX);
    end

    assign captured_number = capturedNum_q;
    assign digit_bcd       = digitBcd_q;
    assign frame_valid     = frameValid_q;
    assign decode_error    = decodeErr_q;
    assign stale           = stale_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Randomised and directed scoreboard bench for seven_seg_capture, driven by an
// abstract digit-presentation model of the display scan.
`timescale 1ns/1ps
module tb_seven_seg_capture;

    localparam int SETTLE    = 16;
    localparam int TIMEOUT   = 600;
    localparam int HALF      = 5;
    localparam logic [6:0] BLANK_SEG = 7'b1111111;

    logic        clock;
    logic        reset;
    logic [3:0]  anode;
    logic [6:0]  cathode;
    logic [15:0] captured_number;
    logic [15:0] digit_bcd;
    logic        frame_valid;
    logic        decode_error;
    logic        stale;

    seven_seg_capture #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock_100Mhz      (clock),
        .reset             (reset),
        .Anode_Activate_in (anode),
        .LED_out_in        (cathode),
        .captured_number   (captured_number),
        .digit_bcd         (digit_bcd),
        .frame_valid       (frame_valid),
        .decode_error      (decode_error),
        .stale             (stale)
    );

    initial clock = 1'b0;
    always #HALF clock = ~clock;

    logic [6:0] segTable [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                   7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    typedef struct {
        bit          isFrame;
        logic [15:0] num;
        logic [15:0] bcd;
    } expect_t;

    expect_t expQ[$];

    int checks = 0;
    int errors = 0;

    // Reference model: which anode was last presented, how many in-order digits are held.
    int          lastAnode;
    int          nextIdx;
    int          digits [4];
    logic [15:0] modelNum;
    logic [15:0] modelBcd;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [3:0] anodeCodeOf(input int idx);
        if (idx < 0) return 4'b1111;
        return ~(4'b1000 >> idx);
    endfunction

    function automatic int patternToDigit(input logic [6:0] p);
        for (int i = 0; i < 10; i++) begin
            if (segTable[i] == p) return i;
        end
        return -1;
    endfunction

    function automatic logic [6:0] randomInvalid();
        logic [6:0] p;
        do begin
            p = 7'($urandom);
        end while (patternToDigit(p) >= 0);
        return p;
    endfunction

    function automatic logic [6:0] randomPattern();
        if ($urandom_range(0, 5) == 0) return randomInvalid();
        return segTable[$urandom_range(0, 9)];
    endfunction

    task automatic modelReset();
        lastAnode = -1;
        nextIdx   = 0;
        modelNum  = 16'd0;
        modelBcd  = 16'd0;
        for (int i = 0; i < 4; i++) digits[i] = 0;
    endtask

    task automatic modelPresent(input int idx, input logic [6:0] pat);
        int d;
        if (idx < 0) begin
            lastAnode = -1;
            return;
        end
        if (idx == lastAnode) return;
        lastAnode = idx;
        d = patternToDigit(pat);
        if (d < 0) begin
            expQ.push_back('{1'b0, modelNum, modelBcd});
            nextIdx = 0;
        end else if (idx == 0) begin
            digits[0] = d;
            nextIdx   = 1;
        end else if (idx == nextIdx) begin
            digits[idx] = d;
            nextIdx++;
            if (nextIdx == 4) begin
                modelNum = 16'(digits[0] * 1000 + digits[1] * 100 + digits[2] * 10 + digits[3]);
                modelBcd = {4'(digits[0]), 4'(digits[1]), 4'(digits[2]), 4'(digits[3])};
                expQ.push_back('{1'b1, modelNum, modelBcd});
                nextIdx = 0;
            end
        end else begin
            nextIdx = 0;
        end
    endtask

    task automatic drivePresentation(input int idx, input logic [6:0] pat);
        @(negedge clock);
        anode   = anodeCodeOf(idx);
        cathode = pat;
        modelPresent(idx, pat);
    endtask

    task automatic applyStimulus(input int idx, input logic [6:0] pat, input int hold);
        drivePresentation(idx, pat);
        repeat (hold) @(negedge clock);
    endtask

    task automatic scanDigits(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                              input logic [6:0] p3, input int hold, input int gap);
        logic [6:0] p [4];
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i, p[i], hold);
            if (gap > 0) applyStimulus(-1, BLANK_SEG, gap);
        end
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s: got %0d events still pending expected 0", name, expQ.size());
            expQ.delete();
        end
    endtask

    // Monitor: every output pulse consumes one expected event.
    always @(negedge clock) begin : monitor
        expect_t e;
        if (!reset && (frame_valid || decode_error)) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse: got frame_valid=%0b decode_error=%0b expected none",
                         frame_valid, decode_error);
            end else begin
                e = expQ.pop_front();
                checkOutput("pulse_kind", 32'({frame_valid, decode_error}), e.isFrame ? 32'd2 : 32'd1);
                checkOutput("captured_number", 32'(captured_number), 32'(e.num));
                checkOutput("digit_bcd", 32'(digit_bcd), 32'(e.bcd));
            end
        end
    end

    initial begin
        #(60000 * 2 * HALF);
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        reset   = 1'b1;
        anode   = 4'b1111;
        cathode = BLANK_SEG;
        modelReset();
        repeat (4) @(negedge clock);
        checkOutput("reset_number", 32'(captured_number), 32'd0);
        checkOutput("reset_bcd", 32'(digit_bcd), 32'd0);
        checkOutput("reset_frame_valid", 32'(frame_valid), 32'd0);
        checkOutput("reset_decode_error", 32'(decode_error), 32'd0);
        checkOutput("reset_stale", 32'(stale), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        $display("[TB] scan 3248");
        scanDigits(segTable[3], segTable[2], segTable[4], segTable[8], 200, 0);
        checkOutput("scan_stale_low", 32'(stale), 32'd0);
        waitDrain("drain_3248");
        checkOutput("number_3248", 32'(captured_number), 32'd3248);
        checkOutput("bcd_3248", 32'(digit_bcd), 32'h3248);

        $display("[TB] scan with bad digit 2");
        scanDigits(segTable[3], segTable[2], BLANK_SEG, segTable[8], 200, 0);
        waitDrain("drain_bad_digit");
        checkOutput("number_kept", 32'(captured_number), 32'd3248);
        checkOutput("bcd_kept", 32'(digit_bcd), 32'h3248);

        $display("[TB] out of order scan 1,0,2,3");
        applyStimulus(1, segTable[1], 200);
        applyStimulus(0, segTable[2], 200);
        applyStimulus(2, segTable[3], 200);
        applyStimulus(3, segTable[4], 200);
        waitDrain("drain_out_of_order");
        checkOutput("number_after_disorder", 32'(captured_number), 32'd3248);

        $display("[TB] blanked scan 9999");
        scanDigits(segTable[9], segTable[9], segTable[9], segTable[9], 100, 50);
        waitDrain("drain_9999");
        checkOutput("number_9999", 32'(captured_number), 32'd9999);
        checkOutput("bcd_9999", 32'(digit_bcd), 32'h9999);

        $display("[TB] stale timeout");
        drivePresentation(0, segTable[5]);
        repeat (TIMEOUT + 10) @(negedge clock);
        checkOutput("stale_set", 32'(stale), 32'd1);
        drivePresentation(1, segTable[6]);
        w = 0;
        while (stale && w < 3) begin
            @(negedge clock);
            w++;
        end
        checkOutput("stale_clear", 32'(stale), 32'd0);
        repeat (40) @(negedge clock);
        applyStimulus(-1, BLANK_SEG, 20);
        waitDrain("drain_timeout");

        $display("[TB] reset mid-frame");
        applyStimulus(0, segTable[1], 60);
        applyStimulus(1, segTable[2], 60);
        applyStimulus(2, segTable[3], 60);
        @(negedge clock);
        reset   = 1'b1;
        anode   = 4'b1111;
        cathode = BLANK_SEG;
        modelReset();
        repeat (3) @(negedge clock);
        checkOutput("midreset_number", 32'(captured_number), 32'd0);
        checkOutput("midreset_bcd", 32'(digit_bcd), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        scanDigits(segTable[0], segTable[0], segTable[0], segTable[7], 60, 0);
        applyStimulus(-1, BLANK_SEG, 20);
        waitDrain("drain_after_reset");
        checkOutput("number_7", 32'(captured_number), 32'd7);
        checkOutput("bcd_7", 32'(digit_bcd), 32'h0007);

        $display("[TB] random ordered scans");
        for (int s = 0; s < 8; s++) begin
            for (int i = 0; i < 4; i++) begin
                applyStimulus(i, randomPattern(), int'($urandom_range(30, 90)));
                if ($urandom_range(0, 2) == 0) applyStimulus(-1, BLANK_SEG, int'($urandom_range(3, 20)));
            end
        end

        $display("[TB] random presentations");
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                applyStimulus(-1, BLANK_SEG, int'($urandom_range(3, 20)));
            end else begin
                applyStimulus(int'($urandom_range(0, 3)), randomPattern(), int'($urandom_range(30, 90)));
            end
        end
        applyStimulus(-1, BLANK_SEG, 40);
        waitDrain("drain_random");
        checkOutput("final_number", 32'(captured_number), 32'(modelNum));
        checkOutput("final_bcd", 32'(digit_bcd), 32'(modelBcd));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
